mem_arbiter: RTL and testbench

//  Parametrised N-port front end to the single-port synchronous sram; successor to the fixed 1-CPU/1-SRAM hookup.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the mem_arbiter slice.
//   clog2     : ceiling log2 helper for sizing ids and counters
//   PORT_IDW  : width of an encoded port id. It is sized for the largest legal
//               port count so the tag layout does not depend on NPORT.
//   tag_t     : one tag-pipe entry {vld, id}
//   MAX_LAT   : upper bound on the supported sram read latency
package mem_arb_pkg;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    localparam int NPORT_MAX = 8;
    localparam int PORT_IDW  = clog2(NPORT_MAX);
    localparam int MAX_LAT   = 4;

    // vld marks an accepted read. Writes travel through the pipe as bubbles.
    typedef struct packed {
        logic                vld;
        logic [PORT_IDW-1:0] id;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational single-grant arbiter.
//   valid   in  NPORT     request vector
//   ptr     in  PORT_IDW  round-robin start position (ignored in fixed priority)
//   grant   out NPORT     one-hot grant, zero when nothing is valid
//   gnt_id  out PORT_IDW  encoded index of the granted port
//   gnt_any out 1         any grant this cycle
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
// Without it, the scan starts at ptr and wraps around the ports.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORT = 4
) (
    input  logic [NPORT-1:0]    valid,
    input  logic [PORT_IDW-1:0] ptr,
    output logic [NPORT-1:0]    grant,
    output logic [PORT_IDW-1:0] gnt_id,
    output logic                gnt_any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        // Scan from the top down so the lowest valid index wins.
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (valid[i]) begin
                gnt_id  = PORT_IDW'(i);
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) grant = NPORT'(1) << gnt_id;
    end
`else
    logic [2*NPORT-1:0] dbl;
    int                 s;

    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        s       = 0;
        // Rotate so bit k is port (ptr+k) mod NPORT. Scan from the top down so
        // the closest valid port at or after ptr wins.
        dbl = {valid, valid} >> ptr;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                s = int'(ptr) + k;
                if (s >= NPORT) s = s - NPORT;
                gnt_id  = PORT_IDW'(s);
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) grant = NPORT'(1) << gnt_id;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port valid/ready front end to a single-port synchronous sram.
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/ready/we   per-port request handshake and direction (1=write)
//   req_addr/req_wdata   packed per-port payload, port i at [i*AW +: AW] / [i*DW +: DW]
//   rsp_valid/rsp_rdata  one-cycle read response, routed to the issuing port
//   sram_addr/din/we     sram command, driven in the grant cycle
//   sram_dout            sram read data, valid SRAM_LAT cycles after the read
// Handshake: a request transfers on req_valid[i] & req_ready[i]. req_ready
// is combinational from req_valid and the round-robin pointer. Requesters
// hold valid and payload until the request is accepted. Responses cannot
// be back-pressured.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority and removes the pointer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORT    = 4,
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int SRAM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_valid,
    output logic [NPORT-1:0]    req_ready,
    input  logic [NPORT-1:0]    req_we,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT*DW-1:0] req_wdata,
    output logic [NPORT-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_din,
    output logic                sram_we,
    input  logic [DW-1:0]       sram_dout
);

    logic [NPORT-1:0]    valid_m;
    logic [NPORT-1:0]    grant;
    logic [PORT_IDW-1:0] gnt_id;
    logic                gnt_any;
    logic [PORT_IDW-1:0] ptr;

    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_din;
    logic                sel_we;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       din_q;

    tag_t                tag_pipe [SRAM_LAT];
    tag_t                tag_last;

    // Reset is asynchronous. Masking here keeps req_ready low for as long as
    // rst is high.
    assign valid_m = rst ? '0 : req_valid;

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .valid   (valid_m),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign req_ready = grant;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == PORT_IDW'(NPORT - 1)) ? '0 : gnt_id + 1'b1;
        end
    end
`endif

    // Payload mux for the granted port. The grant is one-hot, so at most one
    // port matches.
    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_din  = req_wdata[i*DW +: DW];
                sel_we   = req_we[i];
            end
        end
    end

    // Addr and din hold their last issued values on idle cycles. Only the
    // write enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (gnt_any) begin
            addr_q <= sel_addr;
            din_q  <= sel_din;
        end
    end

    assign sram_addr = gnt_any ? sel_addr : addr_q;
    assign sram_din  = gnt_any ? sel_din  : din_q;
    assign sram_we   = gnt_any & sel_we;

    // The tag pipe tracks the sram read latency. Reset clears it, so reads in
    // flight at reset never respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SRAM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0].vld <= gnt_any & ~sel_we;
            tag_pipe[0].id  <= gnt_id;
            for (int i = 1; i < SRAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_last = tag_pipe[SRAM_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (tag_last.vld && (tag_last.id == PORT_IDW'(i))) rsp_valid[i] = 1'b1;
        end
    end

    assign rsp_rdata = tag_last.vld ? sram_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int NPORT = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LAT   = 3;

    logic                clk;
    logic                rst;
    logic [NPORT-1:0]    req_valid;
    logic [NPORT-1:0]    req_ready;
    logic [NPORT-1:0]    req_we;
    logic [NPORT*AW-1:0] req_addr;
    logic [NPORT*DW-1:0] req_wdata;
    logic [NPORT-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic [AW-1:0]       sram_addr;
    logic [DW-1:0]       sram_din;
    logic                sram_we;
    logic [DW-1:0]       sram_dout;

    mem_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .SRAM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we   (sram_we),
        .sram_dout (sram_dout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sram model (write-first, LAT-cycle read) ----------------
    logic [DW-1:0] sram_mem [2**AW];
    logic [DW-1:0] rd_pipe  [LAT];

    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_din;
        rd_pipe[0] <= sram_we ? sram_din : sram_mem[sram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout = rd_pipe[LAT-1];

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    ref_mem [2**AW];
    logic [34:0]      exp_q [$];           // {due_cycle[15:0], port[2:0], data[15:0]}
    logic [AW+DW:0]   pq [NPORT][$];       // per-port pending {we, addr, data}
    int               ptr_m = 0;
    int               want_grant = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [NPORT-1:0] v);
        int g;
        g = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = NPORT - 1; k >= 0; k--) if (v[k]) g = k;
`else
        for (int k = NPORT - 1; k >= 0; k--) if (v[(ptr_m + k) % NPORT]) g = (ptr_m + k) % NPORT;
`endif
        return g;
    endfunction

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int i = 0; i < NPORT; i++) if (pq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pq[p].push_back({we, a, d});
    endtask

    // One clock: check responses, drive held requests, predict and check the grant.
    task automatic cycle();
        logic [34:0]      e;
        logic [AW+DW:0]   c;
        logic [NPORT-1:0] exp_rdy;
        int               g;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0][34:19] == cyc[15:0]) begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << e[18:16]);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e[15:0]));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        for (int i = 0; i < NPORT; i++) begin
            if (pq[i].size() > 0) begin
                c = pq[i][0];
                req_valid[i]             = 1'b1;
                req_we[i]                = c[AW+DW];
                req_addr[i*AW +: AW]     = c[AW+DW-1:DW];
                req_wdata[i*DW +: DW]    = c[DW-1:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        g = rst ? -1 : model_grant(req_valid);
        exp_rdy = (g >= 0) ? (NPORT'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (want_grant >= 0) begin
            chk("post_rst_grant", 32'(req_ready), 32'(1) << want_grant);
            want_grant = -1;
        end
        if (g >= 0) begin
            c = pq[g].pop_front();
            chk("sram_we", 32'(sram_we), 32'(c[AW+DW]));
            chk("sram_addr", 32'(sram_addr), 32'(c[AW+DW-1:DW]));
            if (c[AW+DW]) begin
                chk("sram_din", 32'(sram_din), 32'(c[DW-1:0]));
                ref_mem[c[AW+DW-1:DW]] = c[DW-1:0];
            end else begin
                exp_q.push_back({16'(cyc + LAT), 3'(g), ref_mem[c[AW+DW-1:DW]]});
            end
            ptr_m = (g + 1) % NPORT;
        end else begin
            chk("sram_we_idle", 32'(sram_we), 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
        cycle();
        cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = {8'h33, 8'h22, 8'h11, 8'h44};
        req_wdata = '1;

        // Reset values, with every port requesting.
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_din", 32'(sram_din), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload low memory from port 3.
        for (int a = 0; a < 16; a++) push_req(3, 1'b1, AW'(a), DW'(16'hA000 + a * 16'h0111));
        drain();

        // Reset with two reads in flight; the first grant afterwards is port 0.
        push_req(1, 1'b0, 8'h03, '0);
        push_req(1, 1'b0, 8'h04, '0);
        push_req(2, 1'b0, 8'h05, '0);
        push_req(2, 1'b0, 8'h06, '0);
        cycle();
        cycle();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        exp_q.delete();
        ptr_m = 0;
        push_req(0, 1'b0, 8'h07, '0);
        push_req(3, 1'b0, 8'h08, '0);
        for (int i = 0; i < 3; i++) cycle();
        @(posedge clk);
        #1 rst = 1'b0;
        want_grant = 0;
        drain();

        // Single port write then read back.
        push_req(1, 1'b1, 8'h10, 16'hBEEF);
        push_req(1, 1'b0, 8'h10, '0);
        drain();

        // All ports reading continuously.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NPORT; p++) push_req(p, 1'b0, AW'($urandom_range(0, 15)), '0);
        drain();

        // Back-to-back reads from one port, no bubbles.
        for (int a = 0; a < 8; a++) push_req(2, 1'b0, AW'(a), '0);
        drain();

        // Write from port 0, read of the same address from port 3 on the next grant.
        push_req(0, 1'b1, 8'h20, 16'h1234);
        cycle();
        push_req(3, 1'b0, 8'h20, '0);
        drain();

        // Ports 0 and 2 contending.
        for (int r = 0; r < 6; r++) begin
            push_req(0, 1'b0, AW'(r), '0);
            push_req(2, 1'b0, AW'(r + 8), '0);
        end
        drain();

        // Random read/write mix over a small address range.
        for (int r = 0; r < 40; r++)
            push_req($urandom_range(0, NPORT - 1), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), DW'($urandom_range(0, 16'hFFFF)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
